// File: rtl/ht6221_if.sv
// Signal bundle between the HT6221 IR decoder and its consumer.
// The decoder (master) samples iIR and drives the decoded frame fields and the valid pulse.
interface ht6221_if;
    logic        iIR;
    logic [15:0] irdata;
    logic [15:0] iraddr;
    logic        get_flag;

    modport master (
        input  iIR,
        output irdata,
        output iraddr,
        output get_flag
    );

    modport slave (
        output iIR,
        input  irdata,
        input  iraddr,
        input  get_flag
    );
endinterface

// File: rtl/ht6221_decoder.sv
// HT6221 / NEC-style IR frame decoder: edge-timed leader and bit windows, 32-bit LSB-first frame,
// data byte checked against its inverse, one-clk get_flag pulse on each accepted frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a falling edge (leader start)
// LEAD_LOW  | timing the 9 ms leader burst
// LEAD_HIGH | timing the 4.5 ms leader space
// BIT_LOW   | timing the 560 us burst that opens each bit
// BIT_HIGH  | timing the bit space; its length encodes the bit value
module ht6221_decoder #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic     clk,
    input  logic     rst_n,
    ht6221_if.master ir_bus
);

    function automatic logic [19:0] us_to_cyc(input longint us);
        longint c;
        c = (longint'(CLK_HZ) * us) / 64'sd1_000_000;
        return 20'(c);
    endfunction

    localparam logic [19:0] LEAD_LOW_MIN  = us_to_cyc(8000);
    localparam logic [19:0] LEAD_LOW_MAX  = us_to_cyc(10000);
    localparam logic [19:0] LEAD_HIGH_MIN = us_to_cyc(4000);
    localparam logic [19:0] LEAD_HIGH_MAX = us_to_cyc(5000);
    localparam logic [19:0] BIT_SHORT_MIN = us_to_cyc(400);
    localparam logic [19:0] BIT_SHORT_MAX = us_to_cyc(700);
    localparam logic [19:0] BIT_LONG_MIN  = us_to_cyc(1400);
    localparam logic [19:0] BIT_LONG_MAX  = us_to_cyc(1900);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LEAD_LOW  = 3'd1,
        LEAD_HIGH = 3'd2,
        BIT_LOW   = 3'd3,
        BIT_HIGH  = 3'd4
    } state_t;

    logic        ir_s1;
    logic        ir_s2;
    logic        ir_d;
    logic        fall;
    logic        rise;
    logic [19:0] dur_cnt;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [31:0] frame;
    logic [31:0] frame_next;
    logic [15:0] irdata_r;
    logic [15:0] iraddr_r;
    logic        get_flag_r;

    logic        lead_low_ok;
    logic        lead_high_ok;
    logic        bit_short_ok;
    logic        bit_long_ok;

    // ir_d is the previous synchronized sample, used only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_s1 <= 1'b1;
            ir_s2 <= 1'b1;
            ir_d  <= 1'b1;
        end else begin
            ir_s1 <= ir_bus.iIR;
            ir_s2 <= ir_s1;
            ir_d  <= ir_s2;
        end
    end

    assign fall = ir_d & ~ir_s2;
    assign rise = ~ir_d & ir_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_cnt <= '0;
        end else if (fall || rise) begin
            dur_cnt <= '0;
        end else if (dur_cnt != '1) begin
            dur_cnt <= dur_cnt + 20'd1;
        end
    end

    assign lead_low_ok  = (dur_cnt >= LEAD_LOW_MIN)  && (dur_cnt <= LEAD_LOW_MAX);
    assign lead_high_ok = (dur_cnt >= LEAD_HIGH_MIN) && (dur_cnt <= LEAD_HIGH_MAX);
    assign bit_short_ok = (dur_cnt >= BIT_SHORT_MIN) && (dur_cnt <= BIT_SHORT_MAX);
    assign bit_long_ok  = (dur_cnt >= BIT_LONG_MIN)  && (dur_cnt <= BIT_LONG_MAX);

    // New bits enter at the top so the first bit received ends up in frame[0].
    assign frame_next = {bit_long_ok, frame[31:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            frame      <= '0;
            irdata_r   <= '0;
            iraddr_r   <= '0;
            get_flag_r <= 1'b0;
        end else begin
            get_flag_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= LEAD_LOW;
                        bit_cnt <= '0;
                    end
                end
                LEAD_LOW: begin
                    if (rise) begin
                        state <= lead_low_ok ? LEAD_HIGH : IDLE;
                    end else if (dur_cnt > LEAD_LOW_MAX) begin
                        state <= IDLE;
                    end
                end
                LEAD_HIGH: begin
                    if (fall) begin
                        state <= lead_high_ok ? BIT_LOW : IDLE;
                    end else if (dur_cnt > LEAD_HIGH_MAX) begin
                        state <= IDLE;
                    end
                end
                BIT_LOW: begin
                    if (rise) begin
                        state <= bit_short_ok ? BIT_HIGH : IDLE;
                    end else if (dur_cnt > BIT_SHORT_MAX) begin
                        state <= IDLE;
                    end
                end
                BIT_HIGH: begin
                    if (fall) begin
                        if (bit_short_ok || bit_long_ok) begin
                            frame   <= frame_next;
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                // The falling edge closing bit 32 is the stop burst; IDLE absorbs the rest.
                                state <= IDLE;
                                if (frame_next[31:24] == ~frame_next[23:16]) begin
                                    iraddr_r   <= frame_next[15:0];
                                    irdata_r   <= frame_next[31:16];
                                    get_flag_r <= 1'b1;
                                end
                            end else begin
                                state <= BIT_LOW;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else if (dur_cnt > BIT_LONG_MAX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ir_bus.irdata   = irdata_r;
    assign ir_bus.iraddr   = iraddr_r;
    assign ir_bus.get_flag = get_flag_r;

endmodule

// File: tb/tb_ht6221_decoder.sv
// Randomized bench for ht6221_decoder: stimulus pushes expected frames, a monitor checks each pulse.
`timescale 1ns/1ps
module tb_ht6221_decoder;
    localparam int unsigned CLK_HZ     = 50_000;
    localparam int          US_PER_CLK = 1_000_000 / CLK_HZ;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ht6221_if bus ();

    ht6221_decoder #(.CLK_HZ(CLK_HZ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ir_bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          stop_cyc = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.get_flag === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_flag: got pulse iraddr=%h irdata=%h, expected no pulse",
                         bus.iraddr, bus.irdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.iraddr !== e.addr || bus.irdata !== e.data) begin
                    miscompares++;
                    $display("FAIL frame_fields: got iraddr=%h irdata=%h, expected iraddr=%h irdata=%h",
                             bus.iraddr, bus.irdata, e.addr, e.data);
                end
                vectors++;
                if (cyc - stop_cyc > 4 || cyc - stop_cyc < 1) begin
                    miscompares++;
                    $display("FAIL flag_latency: got %0d clk after stop edge, expected 1..4",
                             cyc - stop_cyc);
                end
            end
        end
    end

    function automatic int rj(input int j);
        if (j == 0) return 0;
        return int'($urandom_range(2 * j)) - j;
    endfunction

    task automatic hold(input logic lvl, input int us);
        bus.iIR = lvl;
        repeat (us / US_PER_CLK) @(negedge clk);
    endtask

    // Reference: a frame produces a pulse iff the leader burst is in its window and inv == ~data.
    task automatic send_frame(input logic [15:0] a, input logic [7:0] d, input logic [7:0] inv,
                              input int lead_us, input int jit);
        logic [31:0] f;
        bit ok;
        f  = {inv, d, a};
        ok = (lead_us >= 8000) && (lead_us <= 10000) && (inv == ~d);
        hold(1'b0, lead_us);
        hold(1'b1, 4500 + rj(jit));
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, 560 + rj(jit));
            hold(1'b1, (f[i] ? 1690 : 560) + rj(jit));
        end
        if (ok) begin
            q.push_back(exp_t'{addr: a, data: {inv, d}});
            last_addr = a;
            last_data = {inv, d};
        end
        stop_cyc = cyc;
        hold(1'b0, 560);
        hold(1'b1, 3000);
    endtask

    task automatic check_hold(input string name);
        vectors++;
        if (bus.iraddr !== last_addr || bus.irdata !== last_data || q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: got iraddr=%h irdata=%h pending=%0d, expected iraddr=%h irdata=%h pending=0",
                     name, bus.iraddr, bus.irdata, q.size(), last_addr, last_data);
        end
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if (bus.iraddr !== 16'h0 || bus.irdata !== 16'h0 || bus.get_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got iraddr=%h irdata=%h get_flag=%b, expected all zero",
                     name, bus.iraddr, bus.irdata, bus.get_flag);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no end of stimulus, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] partial;
        logic [7:0]  rd;
        logic [7:0]  rinv;
        bus.iIR = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        check_reset("reset_values");
        rst_n = 1'b1;
        hold(1'b1, 2000);

        send_frame(16'h0001, 8'h12, 8'hED, 9000, 0);
        check_hold("frame1_outputs");

        hold(1'b1, 60000);
        check_hold("idle_gap_hold");
        send_frame(16'h0003, 8'hEB, 8'h14, 9000, 0);
        check_hold("frame2_outputs");

        send_frame(16'h0003, 8'h12, 8'hEC, 9000, 0);
        check_hold("corrupt_inv_hold");

        send_frame(16'h0003, 8'h55, 8'hAA, 5000, 0);
        check_hold("short_leader_hold");

        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 5000);
        check_hold("repeat_code_hold");

        // Abort mid-frame with reset during bit 10.
        partial = {8'hED, 8'h12, 16'h0001};
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 9; i++) begin
            hold(1'b0, 560);
            hold(1'b1, partial[i] ? 1690 : 560);
        end
        bus.iIR = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("mid_frame_reset");
        last_addr = '0;
        last_data = '0;
        rst_n = 1'b1;
        hold(1'b0, 300);
        hold(1'b1, 10000);
        check_hold("post_reset_hold");
        send_frame(16'h0001, 8'h12, 8'hED, 9000, 0);
        check_hold("post_reset_frame");

        hold(1'b0, 20000);
        hold(1'b1, 5000);
        check_hold("low_timeout_hold");
        send_frame(16'hA5C3, 8'h3C, 8'hC3, 9000, 0);
        check_hold("post_timeout_frame");

        for (int n = 0; n < 6; n++) begin
            rd   = 8'($urandom);
            rinv = ~rd;
            if ($urandom_range(2) == 0) rinv = rinv ^ (8'h01 << $urandom_range(7));
            send_frame(16'($urandom), rd, rinv, 8500 + int'($urandom_range(1000)), 40);
            check_hold("random_frame");
        end

        hold(1'b1, 2000);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_flags: got %0d expected frames without pulse, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
